// File: rtl/game_frame_scheduler.sv
// game_frame_scheduler
// Runs one game frame per physics tick: doodle update -> collision detect ->
// view scroll -> render. Each phase uses a step/done handshake. The block also
// owns the idle/play/game-over flow and the physics tick divider.
module game_frame_scheduler #(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              min_y_crossed,
    input  logic              doodle_done,
    input  logic              collide_done,
    input  logic              view_done,
    input  logic              render_done,
    output logic              doodle_step,
    output logic              collide_step,
    output logic              view_step,
    output logic              render_step,
    output logic [2:0]        phase,
    output logic              game_over,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_err
);

    localparam int unsigned    TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned    PCW       = $clog2(TIMEOUT);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [PCW-1:0] PH_LAST   = PCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_DOODLE  = 3'd2,
        S_COLLIDE = 3'd3,
        S_VIEW    = 3'd4,
        S_RENDER  = 3'd5,
        S_OVER    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic [TCW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [PCW-1:0]      ph_cnt_q, ph_cnt_d;
    logic                doodle_step_q, doodle_step_d;
    logic                collide_step_q, collide_step_d;
    logic                view_step_q, view_step_d;
    logic                render_step_q, render_step_d;
    logic                game_over_q, game_over_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]          overrun_q, overrun_d;
    logic                timeout_q, timeout_d;

    logic                start_rise;
    logic                live_q;
    logic                live_d;
    logic                busy;
    logic                tick;
    logic                phase_done;
    logic                ph_expired;

    assign start_rise = start & ~start_q;
    assign live_q     = (state_q == S_WAIT)    || (state_q == S_DOODLE) ||
                        (state_q == S_COLLIDE) || (state_q == S_VIEW)   ||
                        (state_q == S_RENDER);
    assign busy       = (state_q == S_DOODLE)  || (state_q == S_COLLIDE) ||
                        (state_q == S_VIEW)    || (state_q == S_RENDER);
    assign tick       = (tick_cnt_q == TICK_LAST) & ~pause;
    assign ph_expired = (ph_cnt_q == PH_LAST);

    // Select the done input that belongs to the current phase
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            S_DOODLE:  phase_done = doodle_done;
            S_COLLIDE: phase_done = collide_done;
            S_VIEW:    phase_done = view_done;
            S_RENDER:  phase_done = render_done;
            default:   phase_done = 1'b0;
        endcase
    end

    // Next-state and next-value logic for the game flow and frame sequencing
    always_comb begin
        state_d     = state_q;
        game_over_d = game_over_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d     = S_WAIT;
                    frame_cnt_d = '0;
                    overrun_d   = '0;
                    game_over_d = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    state_d = S_DOODLE;
                end
            end
            S_DOODLE: begin
                if (doodle_done) begin
                    state_d = S_COLLIDE;
                end
            end
            S_COLLIDE: begin
                if (collide_done) begin
                    state_d = S_VIEW;
                end
            end
            S_VIEW: begin
                if (view_done) begin
                    state_d     = S_RENDER;
                    game_over_d = min_y_crossed;
                end
            end
            S_RENDER: begin
                if (render_done) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    state_d     = game_over_q ? S_OVER : S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A phase that never reports done aborts the game; done wins a tie
        if (busy && !phase_done && ph_expired) begin
            state_d     = S_OVER;
            timeout_d   = 1'b1;
            game_over_d = 1'b1;
        end

        // Ticks arriving while a frame is still in flight are dropped and counted
        if (busy && tick && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    assign live_d = (state_d == S_WAIT)    || (state_d == S_DOODLE) ||
                    (state_d == S_COLLIDE) || (state_d == S_VIEW)   ||
                    (state_d == S_RENDER);

    // Tick divider runs only during play and freezes while paused
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!live_q || !live_d) begin
            tick_cnt_d = '0;
        end else if (!pause) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TCW'(1);
        end
    end

    // Per-phase watchdog restarts on every phase entry
    always_comb begin
        ph_cnt_d = '0;
        if (busy && (state_d == state_q)) begin
            ph_cnt_d = ph_cnt_q + PCW'(1);
        end
    end

    // Step pulses mark the first cycle of each phase
    always_comb begin
        doodle_step_d  = (state_d == S_DOODLE)  && (state_q != S_DOODLE);
        collide_step_d = (state_d == S_COLLIDE) && (state_q != S_COLLIDE);
        view_step_d    = (state_d == S_VIEW)    && (state_q != S_VIEW);
        render_step_d  = (state_d == S_RENDER)  && (state_q != S_RENDER);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            tick_cnt_q     <= '0;
            ph_cnt_q       <= '0;
            doodle_step_q  <= 1'b0;
            collide_step_q <= 1'b0;
            view_step_q    <= 1'b0;
            render_step_q  <= 1'b0;
            game_over_q    <= 1'b0;
            frame_cnt_q    <= '0;
            overrun_q      <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            tick_cnt_q     <= tick_cnt_d;
            ph_cnt_q       <= ph_cnt_d;
            doodle_step_q  <= doodle_step_d;
            collide_step_q <= collide_step_d;
            view_step_q    <= view_step_d;
            render_step_q  <= render_step_d;
            game_over_q    <= game_over_d;
            frame_cnt_q    <= frame_cnt_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign phase        = state_q;
    assign doodle_step  = doodle_step_q;
    assign collide_step = collide_step_q;
    assign view_step    = view_step_q;
    assign render_step  = render_step_q;
    assign game_over    = game_over_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun_cnt  = overrun_q;
    assign timeout_err  = timeout_q;

endmodule
